// File: rtl/ic_tester_pkg.sv
// Shared constants for the 14-pin logic IC tester: state encoding,
// IC type codes, per-type output-pin masks and per-type vector counts.
package ic_tester_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [3:0] IC_NAND = 4'd0;
    localparam logic [3:0] IC_AND  = 4'd1;
    localparam logic [3:0] IC_OR   = 4'd2;
    localparam logic [3:0] IC_XOR  = 4'd3;
    localparam logic [3:0] IC_XNOR = 4'd4;
    localparam logic [3:0] IC_NOR  = 4'd5;
    localparam logic [3:0] IC_NOT  = 4'd6;

    // Gate output pins: quad 2-input parts use 2,5,7,10; NOR uses 0,3,9,12;
    // the hex inverter uses 1,3,5,7,9,11.
    localparam logic [13:0] MASK_QUAD = 14'h04A4;
    localparam logic [13:0] MASK_NOR  = 14'h1209;
    localparam logic [13:0] MASK_NOT  = 14'h0AAA;

    // Index of the final vector: four vectors for 2-input parts, two for NOT.
    localparam logic [1:0] VEC_LAST_2IN = 2'd3;
    localparam logic [1:0] VEC_LAST_NOT = 2'd1;

    function automatic logic is_supported(logic [3:0] t);
        return (t <= IC_NOT);
    endfunction

    function automatic logic [13:0] out_mask(logic [3:0] t);
        case (t)
            IC_NAND, IC_AND, IC_OR, IC_XOR, IC_XNOR: return MASK_QUAD;
            IC_NOR:  return MASK_NOR;
            IC_NOT:  return MASK_NOT;
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] last_vec(logic [3:0] t);
        return (t == IC_NOT) ? VEC_LAST_NOT : VEC_LAST_2IN;
    endfunction

    // Gather the bits of v selected by m into consecutive positions, lowest
    // pin first, so bit k corresponds to the k-th output pin of the part.
    function automatic logic [5:0] compact_pins(logic [13:0] m, logic [13:0] v);
        logic [5:0] r;
        logic [2:0] k;
        r = '0;
        k = '0;
        for (int unsigned p = 0; p < 14; p++) begin
            if (m[p]) begin
                r[k] = v[p];
                k    = k + 3'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ic_expected_lut.sv
// Combinational truth-table lookup: IC type and vector index give the
// expected pin levels and the set of pins that take part in the compare.
module ic_expected_lut (
    input  logic [3:0]  ic_type,
    input  logic [1:0]  vec_idx,
    output logic [13:0] expected,
    output logic [13:0] cmp_mask
);
    import ic_tester_pkg::*;

    logic a, b, y;

    // Evaluate one gate for the current vector and replicate onto all outputs.
    always_comb begin
        a = vec_idx[1];
        b = vec_idx[0];
        case (ic_type)
            IC_NAND: y = ~(a & b);
            IC_AND:  y = a & b;
            IC_OR:   y = a | b;
            IC_XOR:  y = a ^ b;
            IC_XNOR: y = ~(a ^ b);
            IC_NOR:  y = ~(a | b);
            IC_NOT:  y = ~b;
            default: y = 1'b0;
        endcase
        cmp_mask = out_mask(ic_type);
        expected = y ? cmp_mask : '0;
    end

endmodule

// File: rtl/ic_test_sequencer.sv
// Test sequencer for 14-pin logic ICs: steps through the truth-table
// vectors of the selected part, waits for the part to settle, samples its
// pins and records the first failing vector and gates.
module ic_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  number,
    input  logic [13:0] gpio_in,
    output logic        step,
    output logic [1:0]  vec_idx,
    output logic        drive_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err,
    output logic [1:0]  fail_idx,
    output logic [5:0]  fail_mask
);
    import ic_tester_pkg::*;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  type_q, type_d;
    logic [1:0]  vec_q, vec_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [13:0] sample_q, sample_d;
    logic        fail_q, fail_d;
    logic        pass_q, pass_d;
    logic        err_q, err_d;
    logic [1:0]  fidx_q, fidx_d;
    logic [5:0]  fmask_q, fmask_d;

    logic [13:0] exp_pins;
    logic [13:0] cmp_mask;
    logic [13:0] mismatch;

    ic_expected_lut u_lut (
        .ic_type  (type_q),
        .vec_idx  (vec_q),
        .expected (exp_pins),
        .cmp_mask (cmp_mask)
    );

    assign mismatch = (sample_q ^ exp_pins) & cmp_mask;

    // Next-state and datapath decisions for the test sequence.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fidx_d   = fidx_q;
        fmask_d  = fmask_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    type_d  = number;
                    vec_d   = '0;
                    fail_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = ~is_supported(number);
                    fidx_d  = '0;
                    fmask_d = '0;
                    state_d = is_supported(number) ? ST_APPLY : ST_DONE;
                end
            end
            ST_APPLY: begin
                cnt_d   = SETTLE_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                sample_d = gpio_in;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch != '0) begin
                    fail_d = 1'b1;
                    if (!fail_q) begin
                        fidx_d  = vec_q;
                        fmask_d = compact_pins(cmp_mask, mismatch);
                    end
                end
                if (vec_q == last_vec(type_q)) begin
                    // The final compare still counts toward the verdict.
                    pass_d  = ~(fail_q | (mismatch != '0));
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any test in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            type_q   <= '0;
            vec_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            fail_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            fidx_q   <= '0;
            fmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
            fmask_q  <= fmask_d;
        end
    end

    assign step      = (state_q == ST_APPLY);
    assign drive_en  = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                       (state_q == ST_SAMPLE) || (state_q == ST_CHECK);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign vec_idx   = vec_q;
    assign pass      = pass_q;
    assign err       = err_q;
    assign fail_idx  = fidx_q;
    assign fail_mask = fmask_q;

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Bench for ic_test_sequencer: models the IC under test (with optional
// stuck pins) and predicts step timing and the verdict from the truth tables.
module tb_ic_test_sequencer;

    localparam int S   = 15;
    localparam int PER = S + 3;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  number;
    logic [13:0] gpio_in;
    logic        step, drive_en, busy, done, pass, err;
    logic [1:0]  vec_idx, fail_idx;
    logic [5:0]  fail_mask;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit f_en  [4];
    int f_pos [4];
    bit f_val [4];

    ic_test_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .number    (number),
        .gpio_in   (gpio_in),
        .step      (step),
        .vec_idx   (vec_idx),
        .drive_en  (drive_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err       (err),
        .fail_idx  (fail_idx),
        .fail_mask (fail_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int npins(int ty);
        if (ty <= 5) return 4;
        if (ty == 6) return 6;
        return 0;
    endfunction

    function automatic int pin_at(int ty, int i);
        int quad [4] = '{2, 5, 7, 10};
        int nor4 [4] = '{0, 3, 9, 12};
        int inv  [6] = '{1, 3, 5, 7, 9, 11};
        if (ty <= 4) return quad[i];
        if (ty == 5) return nor4[i];
        return inv[i];
    endfunction

    function automatic bit gate_out(int ty, int v);
        bit a, b;
        a = ((v >> 1) & 1) != 0;
        b = (v & 1) != 0;
        case (ty)
            0: return !(a && b);
            1: return a && b;
            2: return a || b;
            3: return a != b;
            4: return a == b;
            5: return !(a || b);
            default: return !b;
        endcase
    endfunction

    // Pin levels the physical part drives for vector v; non-output pins are noise.
    function automatic logic [13:0] ic_response(int ty, int v);
        logic [13:0] g;
        bit val;
        g = 14'($urandom);
        for (int i = 0; i < npins(ty); i++) begin
            val = gate_out(ty, v);
            if (f_en[v] && f_pos[v] == i) val = f_val[v];
            g[pin_at(ty, i)] = val;
        end
        return g;
    endfunction

    task automatic clear_faults();
        for (int v = 0; v < 4; v++) begin
            f_en[v] = 1'b0; f_pos[v] = 0; f_val[v] = 1'b0;
        end
    endtask

    task automatic set_fault(input int v, input int pos, input bit val);
        f_en[v] = 1'b1; f_pos[v] = pos; f_val[v] = val;
    endtask

    // One test from start to idle; abort_at > 0 pulses rst in that cycle.
    task automatic run_test(input int num, input bit reassert, input int abort_at);
        int nvec, total, k, phase;
        bit sup, active, found, e_step;
        logic [1:0] e_fidx;
        logic [5:0] e_fmask, m;
        sup   = (num <= 6);
        nvec  = (num == 6) ? 2 : (sup ? 4 : 0);
        total = nvec * PER + 1;
        found = 1'b0; e_fidx = '0; e_fmask = '0;
        for (int v = 0; v < nvec; v++) begin
            m = '0;
            for (int i = 0; i < npins(num); i++)
                if (f_en[v] && f_pos[v] == i && f_val[v] != gate_out(num, v)) m[i] = 1'b1;
            if (m != '0 && !found) begin
                found = 1'b1; e_fidx = 2'(v); e_fmask = m;
            end
        end

        @(negedge clk);
        number = 4'(num);
        start  = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= total + 1; t++) begin
            @(negedge clk);
            start = (reassert && t >= 3 && t <= 6) ? 1'b1 : 1'b0;
            if (t >= 2 && t <= 6) number = 4'($urandom_range(0, 15));
            k      = (t - 1) / PER;
            phase  = (t - 1) % PER;
            active = (t <= nvec * PER);
            gpio_in = active ? ic_response(num, k) : 14'($urandom);
            e_step = active && phase == 0;
            check("ctl{step,drive_en,busy,done}", {step, drive_en, busy, done},
                  {e_step, active, bit'(t <= total), bit'(t == total)});
            if (active) check("vec_idx", vec_idx, k);
            if (t == total || t == total + 1)
                check("result{pass,err,fail_idx,fail_mask}", {pass, err, fail_idx, fail_mask},
                      {bit'(sup && !found), !sup, e_fidx, e_fmask});
            if (abort_at > 0 && t == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check("abort_outputs", {step, vec_idx, drive_en, busy, done, pass, err, fail_idx, fail_mask}, '0);
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check("abort_idle{busy,done}", {busy, done}, 2'b00);
                end
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int num;
        rst = 1'b1; start = 1'b0; number = '0; gpio_in = '0;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {step, vec_idx, drive_en, busy, done, pass, err, fail_idx, fail_mask}, '0);
        rst = 1'b0;

        // Ideal NAND: steps 18 apart, done 73 cycles after accept, pass.
        run_test(0, 1'b0, 0);

        // XOR with pin 7 stuck low on vector 1 and a later stuck pin on vector 3.
        set_fault(1, 2, 1'b0);
        set_fault(3, 0, 1'b1);
        run_test(3, 1'b0, 0);
        check("xor_fail_idx", fail_idx, 2'd1);
        check("xor_fail_mask", fail_mask, 6'b000100);
        check("xor_pass", pass, 1'b0);
        clear_faults();

        // Ideal hex inverter: two vectors, done 37 cycles after accept.
        run_test(6, 1'b0, 0);
        check("not_pass", pass, 1'b1);

        // Unsupported type: immediate done with err.
        run_test(9, 1'b0, 0);
        check("unsup_err", err, 1'b1);

        // Reset during settle of vector 2, after a recorded failure, then a clean run.
        set_fault(1, 1, 1'b0);
        run_test(3, 1'b0, 2 * PER + 9);
        clear_faults();
        run_test(0, 1'b0, 0);
        check("after_abort_pass", pass, 1'b1);

        // Start re-asserted and number changed while busy.
        run_test(5, 1'b1, 0);
        set_fault(0, 5, 1'b1);
        run_test(6, 1'b1, 0);
        clear_faults();

        // Randomized parts, stuck pins and mid-test interference.
        for (int r = 0; r < 14; r++) begin
            num = $urandom_range(0, 9);
            clear_faults();
            if (num <= 6)
                for (int v = 0; v < 4; v++)
                    if ($urandom_range(0, 2) == 0)
                        set_fault(v, $urandom_range(0, npins(num) - 1), 1'($urandom_range(0, 1)));
            run_test(num, (num <= 6) ? 1'($urandom_range(0, 1)) : 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
